// File: rtl/demux1to4_stream.sv
// Stream demultiplexer: one valid/ready input routed by a 2-bit select to four
// valid/ready output channels, each backed by a 2-entry FIFO, with per-channel push counters.
module demux1to4_stream #(
    parameter int N    = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [N-1:0]    in_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [N-1:0]    out_data0,
    output logic [N-1:0]    out_data1,
    output logic [N-1:0]    out_data2,
    output logic [N-1:0]    out_data3,
    output logic [4*CNTW-1:0] word_cnt
);

    logic [1:0]      r_occ   [4];
    logic [N-1:0]    r_head  [4];
    logic [N-1:0]    r_tail  [4];
    logic [CNTW-1:0] r_cnt   [4];
    logic [3:0]      r_valid;

    logic            w_in_ready;
    logic [3:0]      w_push;
    logic [3:0]      w_pop;
    logic [1:0]      w_occ_nxt  [4];
    logic [N-1:0]    w_head_nxt [4];
    logic [N-1:0]    w_tail_nxt [4];

    // Handshake decode: readiness depends only on the selected channel's occupancy.
    always_comb begin
        w_in_ready = ~reset & (r_occ[in_sel] != 2'd2);
        w_push     = 4'b0000;
        w_pop      = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_push[k] = in_valid & w_in_ready & (in_sel == 2'(k));
            w_pop[k]  = r_valid[k] & out_ready[k];
        end
    end

    // Per-channel FIFO next state; the head slot is the registered output word.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_occ_nxt[k]  = r_occ[k];
            w_head_nxt[k] = r_head[k];
            w_tail_nxt[k] = r_tail[k];
            case ({w_push[k], w_pop[k]})
                2'b10: begin
                    if (r_occ[k] == 2'd0) begin
                        w_head_nxt[k] = in_data;
                        w_occ_nxt[k]  = 2'd1;
                    end else begin
                        w_tail_nxt[k] = in_data;
                        w_occ_nxt[k]  = 2'd2;
                    end
                end
                2'b01: begin
                    if (r_occ[k] == 2'd2) begin
                        w_head_nxt[k] = r_tail[k];
                        w_occ_nxt[k]  = 2'd1;
                    end else begin
                        w_occ_nxt[k]  = 2'd0;
                    end
                end
                // push and pop together only happen at occupancy 1
                2'b11: begin
                    w_head_nxt[k] = in_data;
                    w_occ_nxt[k]  = 2'd1;
                end
                default: begin
                    w_occ_nxt[k]  = r_occ[k];
                end
            endcase
        end
    end

    // State registers with synchronous reset discarding any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_occ[k]  <= 2'd0;
                r_head[k] <= {N{1'b0}};
                r_tail[k] <= {N{1'b0}};
                r_cnt[k]  <= {CNTW{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_occ[k]   <= w_occ_nxt[k];
                r_head[k]  <= w_head_nxt[k];
                r_tail[k]  <= w_tail_nxt[k];
                r_valid[k] <= (w_occ_nxt[k] != 2'd0);
                if (w_push[k]) begin
                    r_cnt[k] <= r_cnt[k] + {{(CNTW-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data0 = r_head[0];
    assign out_data1 = r_head[1];
    assign out_data2 = r_head[2];
    assign out_data3 = r_head[3];

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign word_cnt[g*CNTW +: CNTW] = r_cnt[g];
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Randomized and directed bench for demux1to4_stream: per-channel expectation
// queues filled on accepted pushes, drained by a monitor on every observed pop.
module tb_demux1to4_stream;
    localparam int N    = 64;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic [N-1:0]    in_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [N-1:0]    out_data0, out_data1, out_data2, out_data3;
    logic [4*CNTW-1:0] word_cnt;

    logic [N-1:0]    od [4];
    logic [N-1:0]    exp_q [4][$];
    int              mcnt [4];
    int              n_tests = 0;
    int              n_fail  = 0;
    bit              rnd_done;

    demux1to4_stream #(.N(N), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: occupancy is simply the queue length.
    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = !reset && (exp_q[in_sel].size() != 2);
        check("in_ready", N'(in_ready), N'(exp_ready));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid%0d", k), N'(out_valid[k]), N'(exp_q[k].size() != 0));
            if (exp_q[k].size() != 0)
                check($sformatf("out_data%0d", k), od[k], exp_q[k][0]);
            check($sformatf("word_cnt%0d", k), N'(word_cnt[k*CNTW +: CNTW]), N'(mcnt[k] % 16));
        end
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                mcnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                if (exp_q[k].size() != 0 && out_ready[k])
                    void'(exp_q[k].pop_front());
            if (in_valid && exp_ready) begin
                exp_q[in_sel].push_back(in_data);
                mcnt[in_sel]++;
            end
        end
    end

    task automatic do_push(input logic [1:0] s, input logic [N-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got no acceptance expected acceptance within 40 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h0BAD; out_ready = 4'h0;

        // 1 reset with in_valid high
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", N'(in_ready), N'(1'b0));
            check("rst_out_valid", N'(out_valid), N'(4'b0000));
            check("rst_word_cnt", N'(word_cnt), N'(16'h0000));
        end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", N'(in_ready), N'(1'b1));

        // 2 route to each channel
        @(posedge clk); #1;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) do_push(2'(k), 64'hA0 + 64'(k));
        idle(2);
        check("route_word_cnt", N'(word_cnt), N'(16'h1111));

        // 3 fill ch2, then ch0 still accepted, then drain ch2 in order
        out_ready = 4'h0;
        do_push(2'd2, 64'h11);
        do_push(2'd2, 64'h22);
        in_sel = 2'd2;
        @(negedge clk);
        check("full_in_ready", N'(in_ready), N'(1'b0));
        @(posedge clk); #1;
        do_push(2'd0, 64'h44);
        out_ready = 4'b0100;
        do_push(2'd2, 64'h33);
        out_ready = 4'hF;
        idle(4);

        // 4 simultaneous push and pop on ch1
        out_ready = 4'h0;
        do_push(2'd1, 64'h55);
        out_ready = 4'b0010;
        do_push(2'd1, 64'h66);
        out_ready = 4'h0;
        @(negedge clk);
        check("simul_head", out_data1, 64'h66);
        @(posedge clk); #1;
        do_push(2'd1, 64'h77);
        out_ready = 4'b0010;
        do_push(2'd1, 64'h88);
        idle(4);

        // 6 reset in the middle of traffic
        out_ready = 4'h0;
        do_push(2'd0, 64'h1);
        do_push(2'd0, 64'h2);
        do_push(2'd1, 64'h3);
        reset = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 64'hDEAD;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", N'(out_valid), N'(4'b0000));
        check("midrst_word_cnt", N'(word_cnt), N'(16'h0000));
        @(posedge clk); #1;
        out_ready = 4'hF;
        idle(3);

        // 5 counter wrap on ch3
        for (int i = 0; i < 17; i++) do_push(2'd3, 64'(i) + 64'h300);
        @(negedge clk);
        check("wrap_word_cnt3", N'(word_cnt[3*CNTW +: CNTW]), N'(4'd1));
        @(posedge clk); #1;

        // random traffic with random consumer back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    do_push(2'($urandom_range(0, 3)), {$urandom, $urandom});
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 4'($urandom);
                end
            end
        join
        out_ready = 4'hF;
        idle(4);
        @(negedge clk);
        check("drain_out_valid", N'(out_valid), N'(4'b0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
